exe_hazard_ctrl: RTL and testbench

Pipeline controller for the EXE stage. Generates the registered forwarding selects for the EXE operand muxes and the load-use stall (`hazard_ID`). Produces the global `freeze` while a MEM-stage cache access is outstanding, and the IF/ID `flush` on a taken branch. A watchdog raises a sticky error if the cache never answers. It sits beside the ID/EXE pipeline register and drives the stage freeze lines.

---
 rtl/exe_ctrl_pkg.sv | 15 +
 rtl/exe_hazard_ctrl_if.sv | 41 ++++
 rtl/exe_fwd_decode.sv | 37 +++
 rtl/exe_hazard_ctrl.sv | 119 +++++++++++
 tb/tb_exe_hazard_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_ctrl_pkg.sv
// Shared types and constants for the EXE-stage hazard controller.
// Memory FSM state encoding and the operand-mux select codes live here.
package exe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } mem_st_t;

    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_MEM = 2'd1;
    localparam logic [1:0] SEL_WB  = 2'd2;

endpackage

// File: rtl/exe_hazard_ctrl_if.sv
// Pipeline-side signal bundle for exe_hazard_ctrl.
// The pipeline (master) drives instruction/cache status; the controller (slave) drives selects and stage control.
interface exe_hazard_ctrl_if;

    logic       fwd_en;
    logic [3:0] src1_ID;
    logic [3:0] src2_ID;
    logic       two_src_ID;
    logic [3:0] dest_EXE;
    logic       WB_EN_EXE;
    logic       MEM_R_EN_EXE;
    logic [3:0] dest_MEM;
    logic       WB_EN_MEM;
    logic       MEM_R_EN_MEM;
    logic       MEM_W_EN_MEM;
    logic       B_EXE;
    logic       cache_ready;
    logic [1:0] sel_src1_FWRD;
    logic [1:0] sel_src2_FWRD;
    logic       hazard_ID;
    logic       freeze;
    logic       flush;
    logic       timeout_err;

    modport master (
        output fwd_en, src1_ID, src2_ID, two_src_ID,
               dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM,
               B_EXE, cache_ready,
        input  sel_src1_FWRD, sel_src2_FWRD, hazard_ID, freeze, flush, timeout_err
    );

    modport slave (
        input  fwd_en, src1_ID, src2_ID, two_src_ID,
               dest_EXE, WB_EN_EXE, MEM_R_EN_EXE,
               dest_MEM, WB_EN_MEM, MEM_R_EN_MEM, MEM_W_EN_MEM,
               B_EXE, cache_ready,
        output sel_src1_FWRD, sel_src2_FWRD, hazard_ID, freeze, flush, timeout_err
    );

endinterface

// File: rtl/exe_fwd_decode.sv
// Combinational forward/hazard decode for one ID-stage source operand.
// EXE producer has priority over MEM; with forwarding disabled every match stalls.
module exe_fwd_decode
    import exe_ctrl_pkg::*;
(
    input  logic       fwd_en,
    input  logic [3:0] src,
    input  logic       used,
    input  logic [3:0] dest_exe,
    input  logic       wb_en_exe,
    input  logic       mem_r_en_exe,
    input  logic [3:0] dest_mem,
    input  logic       wb_en_mem,
    output logic [1:0] sel,
    output logic       hazard
);

    logic hit_exe;
    logic hit_mem;

    assign hit_exe = used && wb_en_exe && (dest_exe == src);
    assign hit_mem = used && wb_en_mem && (dest_mem == src);

    always_comb begin
        sel = SEL_RF;
        if (fwd_en) begin
            if (hit_exe)
                sel = SEL_MEM;
            else if (hit_mem)
                sel = SEL_WB;
        end
    end

    // A load in EXE has no result yet, so only it can stall when forwarding is on.
    assign hazard = fwd_en ? (hit_exe && mem_r_en_exe) : (hit_exe || hit_mem);

endmodule

// File: rtl/exe_hazard_ctrl.sv
// EXE-stage pipeline controller: registered forwarding selects, load-use stall,
// cache-miss freeze with watchdog, and branch flush of IF/ID.
module exe_hazard_ctrl
    import exe_ctrl_pkg::*;
#(
    parameter int MISS_TIMEOUT = 255,
    parameter int CW           = $clog2(MISS_TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    exe_hazard_ctrl_if.slave   bus
);

    mem_st_t       mem_st;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          err_q;
    logic [1:0]    sel1_q;
    logic [1:0]    sel2_q;

    logic [1:0]    dec_sel1;
    logic [1:0]    dec_sel2;
    logic          haz1;
    logic          haz2;
    logic          mem_req;
    logic          freeze_raw;
    logic          freeze_int;
    logic          flush_int;
    logic          hazard_int;

    exe_fwd_decode u_dec_src1 (
        .fwd_en       (bus.fwd_en),
        .src          (bus.src1_ID),
        .used         (1'b1),
        .dest_exe     (bus.dest_EXE),
        .wb_en_exe    (bus.WB_EN_EXE),
        .mem_r_en_exe (bus.MEM_R_EN_EXE),
        .dest_mem     (bus.dest_MEM),
        .wb_en_mem    (bus.WB_EN_MEM),
        .sel          (dec_sel1),
        .hazard       (haz1)
    );

    exe_fwd_decode u_dec_src2 (
        .fwd_en       (bus.fwd_en),
        .src          (bus.src2_ID),
        .used         (bus.two_src_ID),
        .dest_exe     (bus.dest_EXE),
        .wb_en_exe    (bus.WB_EN_EXE),
        .mem_r_en_exe (bus.MEM_R_EN_EXE),
        .dest_mem     (bus.dest_MEM),
        .wb_en_mem    (bus.WB_EN_MEM),
        .sel          (dec_sel2),
        .hazard       (haz2)
    );

    assign mem_req    = bus.MEM_R_EN_MEM | bus.MEM_W_EN_MEM;
    // Combinational so that a cache hit never costs a freeze cycle.
    assign freeze_raw = (mem_st == ERR) || (mem_req && !bus.cache_ready);
    assign freeze_int = rst && freeze_raw;
    assign flush_int  = rst && bus.B_EXE && !freeze_raw;
    assign hazard_int = rst && (haz1 || haz2) && !flush_int;
    assign cnt_nxt    = cnt + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_st <= IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            sel1_q <= SEL_RF;
            sel2_q <= SEL_RF;
        end else begin
            case (mem_st)
                IDLE: begin
                    if (mem_req && !bus.cache_ready) begin
                        mem_st <= WAIT;
                        cnt    <= '0;
                    end
                end
                WAIT: begin
                    cnt <= cnt_nxt;
                    // A ready arriving on the timeout cycle still completes the access.
                    if (bus.cache_ready) begin
                        mem_st <= IDLE;
                    end else if (cnt_nxt == CW'(MISS_TIMEOUT)) begin
                        mem_st <= ERR;
                        err_q  <= 1'b1;
                    end
                end
                ERR: begin
                    mem_st <= ERR;
                    err_q  <= 1'b1;
                end
                default: begin
                    mem_st <= IDLE;
                    cnt    <= '0;
                end
            endcase

            if (!freeze_raw) begin
                if (flush_int || hazard_int) begin
                    sel1_q <= SEL_RF;
                    sel2_q <= SEL_RF;
                end else begin
                    sel1_q <= dec_sel1;
                    sel2_q <= dec_sel2;
                end
            end
        end
    end

    assign bus.sel_src1_FWRD = sel1_q;
    assign bus.sel_src2_FWRD = sel2_q;
    assign bus.hazard_ID     = hazard_int;
    assign bus.freeze        = freeze_int;
    assign bus.flush         = flush_int;
    assign bus.timeout_err   = err_q;

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Self-checking bench for exe_hazard_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the forwarding/stall/miss rules.
module tb_exe_hazard_ctrl;

    localparam int MT = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [1:0] m_sel1, m_sel2;
    bit         m_err;
    int         n_run;      // consecutive cycles the current access has gone unanswered
    logic       obs_haz, obs_frz, obs_fls;

    exe_hazard_ctrl_if bus ();

    exe_hazard_ctrl #(.MISS_TIMEOUT(MT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [3:0] s, input logic used);
        if (!bus.fwd_en || !used) return 2'd0;
        if (bus.WB_EN_EXE && bus.dest_EXE == s) return 2'd1;
        if (bus.WB_EN_MEM && bus.dest_MEM == s) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic m_stall(input logic [3:0] s, input logic used);
        logic e, m;
        if (!used) return 1'b0;
        e = bus.WB_EN_EXE && bus.dest_EXE == s;
        m = bus.WB_EN_MEM && bus.dest_MEM == s;
        return bus.fwd_en ? (e && bus.MEM_R_EN_EXE) : (e || m);
    endfunction

    task automatic model_reset();
        m_sel1 = 2'd0;
        m_sel2 = 2'd0;
        m_err  = 1'b0;
        n_run  = 0;
    endtask

    task automatic clear_inputs();
        bus.fwd_en       = 1'b1;
        bus.src1_ID      = 4'd0;
        bus.src2_ID      = 4'd0;
        bus.two_src_ID   = 1'b0;
        bus.dest_EXE     = 4'd0;
        bus.WB_EN_EXE    = 1'b0;
        bus.MEM_R_EN_EXE = 1'b0;
        bus.dest_MEM     = 4'd0;
        bus.WB_EN_MEM    = 1'b0;
        bus.MEM_R_EN_MEM = 1'b0;
        bus.MEM_W_EN_MEM = 1'b0;
        bus.B_EXE        = 1'b0;
        bus.cache_ready  = 1'b0;
    endtask

    // Called just after a rising edge with inputs already applied; ends just after the next edge.
    task automatic cycle();
        logic fz, fl, hz, req;
        logic [1:0] d1, d2;
        #4;
        req = bus.MEM_R_EN_MEM | bus.MEM_W_EN_MEM;
        fz  = rst && (m_err || (req && !bus.cache_ready));
        fl  = rst && bus.B_EXE && !fz;
        hz  = rst && !fl && (m_stall(bus.src1_ID, 1'b1) || m_stall(bus.src2_ID, bus.two_src_ID));
        obs_haz = bus.hazard_ID;
        obs_frz = bus.freeze;
        obs_fls = bus.flush;
        chk("freeze", obs_frz, fz);
        chk("flush", obs_fls, fl);
        chk("hazard_ID", obs_haz, hz);
        d1 = m_fwd(bus.src1_ID, 1'b1);
        d2 = m_fwd(bus.src2_ID, bus.two_src_ID);
        if (!rst) begin
            model_reset();
        end else begin
            if (!fz) begin
                m_sel1 = (fl || hz) ? 2'd0 : d1;
                m_sel2 = (fl || hz) ? 2'd0 : d2;
            end
            if (!m_err) begin
                if (bus.cache_ready) n_run = 0;
                else if (n_run > 0 || req) n_run++;
                if (n_run > MT) m_err = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("sel_src1", bus.sel_src1_FWRD, m_sel1);
        chk("sel_src2", bus.sel_src2_FWRD, m_sel2);
        chk("timeout_err", bus.timeout_err, m_err);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        rst = 1'b0;

        // Reset: outputs forced low even with branch, miss and hazard pending
        bus.B_EXE = 1'b1; bus.MEM_R_EN_MEM = 1'b1;
        bus.WB_EN_EXE = 1'b1; bus.MEM_R_EN_EXE = 1'b1; bus.dest_EXE = 4'd1; bus.src1_ID = 4'd1;
        @(posedge clk); #1;
        cycle();
        chk("rst_flush_lit", obs_fls, 1'b0);
        chk("rst_freeze_lit", obs_frz, 1'b0);
        chk("rst_hazard_lit", obs_haz, 1'b0);
        chk("rst_sel1_lit", bus.sel_src1_FWRD, 2'd0);
        rst = 1'b1;
        clear_inputs();
        cycle();

        // Forwarding from EXE then from MEM
        bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 4'd3; bus.src1_ID = 4'd3;
        cycle();
        chk("fwd_exe_lit", bus.sel_src1_FWRD, 2'd1);
        bus.WB_EN_EXE = 1'b0; bus.dest_EXE = 4'd9;
        bus.WB_EN_MEM = 1'b1; bus.dest_MEM = 4'd3;
        cycle();
        chk("fwd_mem_lit", bus.sel_src1_FWRD, 2'd2);

        // Priority of EXE over MEM, and two_src_ID gating
        clear_inputs();
        bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 4'd5;
        bus.WB_EN_MEM = 1'b1; bus.dest_MEM = 4'd5;
        bus.src2_ID = 4'd5; bus.two_src_ID = 1'b1;
        cycle();
        chk("prio_lit", bus.sel_src2_FWRD, 2'd1);
        bus.two_src_ID = 1'b0;
        cycle();
        chk("two_src_off_lit", bus.sel_src2_FWRD, 2'd0);

        // Load-use: one stall, then MEM forward
        clear_inputs();
        bus.WB_EN_EXE = 1'b1; bus.MEM_R_EN_EXE = 1'b1; bus.dest_EXE = 4'd2; bus.src1_ID = 4'd2;
        cycle();
        chk("lu_stall_lit", obs_haz, 1'b1);
        chk("lu_bubble_lit", bus.sel_src1_FWRD, 2'd0);
        bus.WB_EN_EXE = 1'b0; bus.MEM_R_EN_EXE = 1'b0;
        bus.WB_EN_MEM = 1'b1; bus.MEM_R_EN_MEM = 1'b1; bus.dest_MEM = 4'd2; bus.cache_ready = 1'b1;
        cycle();
        chk("lu_release_lit", obs_haz, 1'b0);
        chk("lu_hit_nofreeze_lit", obs_frz, 1'b0);
        chk("lu_sel_lit", bus.sel_src1_FWRD, 2'd2);

        // Forwarding disabled: stall while producer is in EXE and MEM
        clear_inputs();
        bus.fwd_en = 1'b0;
        bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 4'd4; bus.src1_ID = 4'd4;
        cycle();
        chk("nofwd_stall1_lit", obs_haz, 1'b1);
        bus.WB_EN_EXE = 1'b0; bus.WB_EN_MEM = 1'b1; bus.dest_MEM = 4'd4;
        cycle();
        chk("nofwd_stall2_lit", obs_haz, 1'b1);
        chk("nofwd_sel_lit", bus.sel_src1_FWRD, 2'd0);
        bus.WB_EN_MEM = 1'b0;
        cycle();
        chk("nofwd_done_lit", obs_haz, 1'b0);

        // Miss of 5 cycles with a branch waiting; hazard present but frozen
        clear_inputs();
        bus.MEM_R_EN_MEM = 1'b1; bus.B_EXE = 1'b1;
        bus.WB_EN_EXE = 1'b1; bus.dest_EXE = 4'd7; bus.src1_ID = 4'd7;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("miss_freeze_lit", obs_frz, 1'b1);
            chk("miss_noflush_lit", obs_fls, 1'b0);
        end
        bus.cache_ready = 1'b1;
        cycle();
        chk("miss_done_freeze_lit", obs_frz, 1'b0);
        chk("miss_done_flush_lit", obs_fls, 1'b1);
        bus.MEM_R_EN_MEM = 1'b0; bus.B_EXE = 1'b0; bus.cache_ready = 1'b0;
        cycle();
        chk("after_flush_lit", obs_fls, 1'b0);

        // Random traffic; misses are held until answered and answered before the watchdog fires
        for (int i = 0; i < 400; i++) begin
            bus.fwd_en       = ($urandom_range(0, 7) != 0);
            bus.src1_ID      = 4'($urandom_range(0, 5));
            bus.src2_ID      = 4'($urandom_range(0, 5));
            bus.two_src_ID   = 1'($urandom_range(0, 1));
            bus.dest_EXE     = 4'($urandom_range(0, 5));
            bus.WB_EN_EXE    = 1'($urandom_range(0, 1));
            bus.MEM_R_EN_EXE = 1'($urandom_range(0, 1));
            bus.dest_MEM     = 4'($urandom_range(0, 5));
            bus.WB_EN_MEM    = 1'($urandom_range(0, 1));
            bus.B_EXE        = ($urandom_range(0, 4) == 0);
            if (n_run == 0) begin
                bus.MEM_R_EN_MEM = ($urandom_range(0, 3) == 0);
                bus.MEM_W_EN_MEM = ($urandom_range(0, 5) == 0);
            end
            bus.cache_ready = (n_run >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
            cycle();
        end

        // Watchdog: no answer at all
        clear_inputs();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        bus.MEM_R_EN_MEM = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("wd_pre_lit", bus.timeout_err, 1'b0);
        cycle();
        chk("wd_err_lit", bus.timeout_err, 1'b1);
        bus.MEM_R_EN_MEM = 1'b0; bus.cache_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("wd_sticky_lit", bus.timeout_err, 1'b1);
            chk("wd_freeze_lit", obs_frz, 1'b1);
        end

        // Asynchronous reset in the middle of ERR
        bus.B_EXE = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("arst_err_lit", bus.timeout_err, 1'b0);
        chk("arst_freeze_lit", bus.freeze, 1'b0);
        chk("arst_flush_lit", bus.flush, 1'b0);
        chk("arst_sel1_lit", bus.sel_src1_FWRD, 2'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        clear_inputs();
        cycle();
        chk("post_rst_err_lit", bus.timeout_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
